// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin arbiter sharing one combinational ALU between two requesters.
//   Optional feature macro: ALU_ARB_OVF_STICKY_EN adds ovf_sticky_o.
//   Ports:
//     clk, rst_n (async, active-low)           clock and reset
//     sync_clear_i                             drop in-flight op, back to IDLE, reset RR pointer
//     req_valid_i[1:0] / req_ready_o[1:0]      request handshake, ready one-hot in IDLE only
//     req_op0_i/req_a0_i/req_b0_i              requester 0 opcode and operands
//     req_op1_i/req_a1_i/req_b1_i              requester 1 opcode and operands
//     resp_valid_o / resp_ready_i              response handshake
//     resp_id_o, resp_result_o, resp_onz_o     response owner, result, flags {O,N,Z}
//     alu_op_o, alu_a_o, alu_b_o               registered operands to the ALU
//     alu_result_i, alu_onz_i                  combinational ALU result and flags
//     busy_o                                   high in EXEC or RESP
//     ovf_sticky_o[1:0] (macro only)           per-requester sticky overflow
module alu_rr_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sync_clear_i,
  input  logic [1:0]   req_valid_i,
  output logic [1:0]   req_ready_o,
  input  logic [2:0]   req_op0_i,
  input  logic [2:0]   req_op1_i,
  input  logic [N-1:0] req_a0_i,
  input  logic [N-1:0] req_a1_i,
  input  logic [N-1:0] req_b0_i,
  input  logic [N-1:0] req_b1_i,
  output logic         resp_valid_o,
  input  logic         resp_ready_i,
  output logic         resp_id_o,
  output logic [N-1:0] resp_result_o,
  output logic [2:0]   resp_onz_o,
  output logic [2:0]   alu_op_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  input  logic [N-1:0] alu_result_i,
  input  logic [2:0]   alu_onz_i,
  output logic         busy_o
`ifdef ALU_ARB_OVF_STICKY_EN
  ,
  output logic [1:0]   ovf_sticky_o
`endif
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0]   state_q, state_d;
  logic         rr_last_q, rr_last_d;
  logic [2:0]   op_q, op_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic         id_q, id_d, rv_q, rv_d;
  logic [N-1:0] res_q, res_d;
  logic [2:0]   onz_q, onz_d;
  logic [1:0]   gnt;
  logic [2:0]   onz_m;
  // A single valid request is granted as-is; a tie goes to the one that was not served last.
  // Gated by rst_n so every output reads zero while reset is held.
  assign gnt = (rst_n && state_q == IDLE && !sync_clear_i) ?
               ((&req_valid_i) ? (rr_last_q ? 2'b01 : 2'b10) : req_valid_i) : 2'b00;
  // Overflow is only meaningful for ADD (000) and SUB (001).
  assign onz_m = {alu_onz_i[2] & ~|op_q[2:1], alu_onz_i[1:0]};
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    rv_d      = rv_q;
    res_d     = res_q;
    onz_d     = onz_q;
    if (sync_clear_i) begin
      state_d   = IDLE;
      rv_d      = 1'b0;
      rr_last_d = 1'b1;
    end else if (state_q == IDLE && |gnt) begin
      state_d = EXEC;
      id_d    = gnt[1];
      op_d    = gnt[1] ? req_op1_i : req_op0_i;
      a_d     = gnt[1] ? req_a1_i : req_a0_i;
      b_d     = gnt[1] ? req_b1_i : req_b0_i;
    end else if (state_q == EXEC) begin
      state_d = RESP;
      res_d   = alu_result_i;
      onz_d   = onz_m;
      rv_d    = 1'b1;
    end else if (state_q == RESP && resp_ready_i) begin
      state_d   = IDLE;
      rv_d      = 1'b0;
      rr_last_d = id_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      rv_q      <= 1'b0;
      res_q     <= '0;
      onz_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      rv_q      <= rv_d;
      res_q     <= res_d;
      onz_q     <= onz_d;
    end
  end
`ifdef ALU_ARB_OVF_STICKY_EN
  logic [1:0] sticky_q, sticky_d;
  assign sticky_d = sync_clear_i ? 2'b00 :
                    (state_q == EXEC && onz_m[2]) ? (sticky_q | (id_q ? 2'b10 : 2'b01)) : sticky_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 2'b00;
    else sticky_q <= sticky_d;
  end
  assign ovf_sticky_o = sticky_q;
`endif
  assign req_ready_o   = gnt;
  assign resp_valid_o  = rv_q;
  assign resp_id_o     = id_q;
  assign resp_result_o = res_q;
  assign resp_onz_o    = onz_q;
  assign alu_op_o      = op_q;
  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign busy_o        = state_q != IDLE;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: scoreboard bench for alu_rr_arbiter with a stand-in 8-bit ALU.
module tb_alu_rr_arbiter;
  logic       clk = 1'b0, rst_n = 1'b0, sync_clear = 1'b0, resp_ready = 1'b1;
  logic       vld0 = 1'b0, vld1 = 1'b0;
  logic [1:0] req_valid, req_ready;
  logic [2:0] op0 = '0, op1 = '0;
  logic [7:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic       resp_valid, resp_id, busy;
  logic [7:0] resp_result, alu_a, alu_b, alu_result;
  logic [2:0] resp_onz, alu_op, alu_onz;
  logic [1:0] ovf_sticky;
  logic [11:0] exp_q[$];
  logic [11:0] e;
  int tests = 0, fails = 0;
  assign req_valid = {vld1, vld0};
  always #5 clk = ~clk;
  alu_rr_arbiter #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .sync_clear_i(sync_clear),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op0_i(op0), .req_op1_i(op1), .req_a0_i(a0), .req_a1_i(a1), .req_b0_i(b0), .req_b1_i(b1),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_id_o(resp_id),
    .resp_result_o(resp_result), .resp_onz_o(resp_onz),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_result), .alu_onz_i(alu_onz), .busy_o(busy)
`ifdef ALU_ARB_OVF_STICKY_EN
    , .ovf_sticky_o(ovf_sticky)
`endif
  );
`ifndef ALU_ARB_OVF_STICKY_EN
  assign ovf_sticky = 2'b00;
`endif
  // Stand-in ALU; it leaves O high on non-arithmetic ops so the masking is observable.
  always_comb begin
    alu_result = 8'h00;
    alu_onz    = 3'b000;
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = alu_a + 8'h01;
      3'd6: alu_result = alu_a;
      default: alu_result = alu_b;
    endcase
    alu_onz[2] = (alu_op == 3'd0) ? (alu_a[7] == alu_b[7] && alu_result[7] != alu_a[7]) :
                 (alu_op == 3'd1) ? (alu_a[7] != alu_b[7] && alu_result[7] != alu_a[7]) : 1'b1;
    alu_onz[1] = alu_result[7];
    alu_onz[0] = alu_result == 8'h00;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  // Monitor: one-hot ready every cycle, and scoreboard pop on every response handshake.
  always @(negedge clk) begin
    chk("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp_unexpected: got id=%0d result=0x%0h onz=%b with nothing expected", resp_id, resp_result, resp_onz);
      end else begin
        e = exp_q.pop_front();
        chk("resp {id,result,onz}", {resp_id, resp_result, resp_onz}, e);
      end
    end
  end
  task automatic issue(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [10:0] exp, input bit push);
    bit ok = 1'b0;
    if (push) exp_q.push_back({id, exp});
    if (id) begin op1 = op; a1 = a; b1 = b; vld1 = 1'b1; end
    else begin op0 = op; a0 = a; b0 = b; vld0 = 1'b1; end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready[id];
    end
    @(posedge clk);
    #1;
    if (id) vld1 = 1'b0;
    else vld0 = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL grant%0d: no req_ready within 50 cycles", id);
    end
  endtask
  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = exp_q.size() == 0 && !busy;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d responses still pending after 50 cycles", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wait_resp(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = resp_valid;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s: resp_valid never rose within 50 cycles", nm);
    end
  endtask
  initial begin
    #12;
    chk("reset_outs", {req_ready, resp_valid, resp_id, resp_result, resp_onz, alu_op, alu_a, alu_b, busy, ovf_sticky}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Signed overflow on ADD, with the latency check.
    issue(1'b0, 3'd0, 8'h7F, 8'h01, {8'h80, 3'b110}, 1'b1);
    @(negedge clk);
    chk("t1_exec_no_valid", {busy, resp_valid}, 2'b10);
    chk("t1_alu_operands", {alu_op, alu_a, alu_b}, {3'd0, 8'h7F, 8'h01});
    @(negedge clk);
    chk("t1_latency_valid", resp_valid, 1'b1);
    drain();
    issue(1'b1, 3'd1, 8'h05, 8'h05, {8'h00, 3'b001}, 1'b1);
    drain();
    issue(1'b1, 3'd4, 8'h80, 8'h00, {8'h80, 3'b010}, 1'b1);
    drain();
    // Both requesters always valid: order must alternate 0,1,0,1.
    exp_q.push_back({1'b0, 8'h30, 3'b000});
    exp_q.push_back({1'b1, 8'hFF, 3'b010});
    exp_q.push_back({1'b0, 8'h80, 3'b010});
    exp_q.push_back({1'b1, 8'h00, 3'b001});
    fork
      begin issue(1'b0, 3'd2, 8'hF0, 8'h3C, '0, 1'b0); issue(1'b0, 3'd5, 8'h7F, 8'h00, '0, 1'b0); end
      begin issue(1'b1, 3'd3, 8'h0F, 8'hF0, '0, 1'b0); issue(1'b1, 3'd7, 8'h12, 8'h00, '0, 1'b0); end
    join
    drain();
    // Response back-pressure: outputs frozen, no grants, requester 1 next after the handshake.
    resp_ready = 1'b0;
    exp_q.push_back({1'b0, 8'hFF, 3'b010});
    exp_q.push_back({1'b1, 8'h5A, 3'b000});
    fork
      issue(1'b0, 3'd1, 8'h00, 8'h01, '0, 1'b0);
      issue(1'b1, 3'd6, 8'h5A, 8'h77, '0, 1'b0);
      begin
        wait_resp("t4_resp");
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_resp", {resp_valid, resp_id, resp_result, resp_onz}, {1'b1, 1'b0, 8'hFF, 3'b010});
          chk("stall_ready", {busy, req_ready}, 3'b100);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("grant_after_stall", req_ready, 2'b10);
      end
    join
    drain();
    // sync_clear during EXEC: op dropped, pointer back to requester 0.
    issue(1'b0, 3'd6, 8'h33, 8'h00, {8'h33, 3'b000}, 1'b1);
    drain();
    op1 = 3'd0; a1 = 8'h01; b1 = 8'h01; vld1 = 1'b1;
    wait_resp_grant: for (int i = 0; i < 50 && !req_ready[1]; i++) @(negedge clk);
    chk("clr_pre_grant1", req_ready, 2'b10);
    @(posedge clk);
    #1 vld0 = 1'b1;
    sync_clear = 1'b1;
    @(negedge clk);
    chk("clr_exec_ready", {resp_valid, req_ready}, 3'b000);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("clr_idle", {busy, resp_valid, req_ready}, 4'b0000);
    @(posedge clk);
    #1 sync_clear = 1'b0;
    @(negedge clk);
    chk("clr_winner", req_ready, 2'b01);
    vld0 = 1'b0;
    vld1 = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back({1'b0, 8'h02, 3'b000});
    exp_q.push_back({1'b1, 8'h00, 3'b101});
    fork
      issue(1'b0, 3'd0, 8'h01, 8'h01, '0, 1'b0);
      issue(1'b1, 3'd0, 8'h80, 8'h80, '0, 1'b0);
    join
    drain();
`ifdef ALU_ARB_OVF_STICKY_EN
    chk("sticky_set", ovf_sticky, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    chk("sticky_held", ovf_sticky, 2'b10);
    sync_clear = 1'b1;
    @(posedge clk);
    #1 sync_clear = 1'b0;
    chk("sticky_cleared", ovf_sticky, 2'b00);
`endif
    // Async reset while a response is pending: everything zero, pointer back to requester 0.
    issue(1'b0, 3'd7, 8'h00, 8'hC3, {8'hC3, 3'b010}, 1'b1);
    drain();
    resp_ready = 1'b0;
    issue(1'b1, 3'd0, 8'h10, 8'h20, '0, 1'b0);
    wait_resp("t5_resp");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {req_ready, resp_valid, resp_id, resp_result, resp_onz, alu_op, alu_a, alu_b, busy, ovf_sticky}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    resp_ready = 1'b1;
    exp_q.push_back({1'b0, 8'hFF, 3'b010});
    exp_q.push_back({1'b1, 8'h00, 3'b001});
    fork
      issue(1'b0, 3'd4, 8'hAA, 8'h55, '0, 1'b0);
      issue(1'b1, 3'd2, 8'hAA, 8'h55, '0, 1'b0);
    join
    drain();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
